// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame receiver and its helpers.
package spi_frame_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RESYNC,
    IDLE,
    COLLECT,
    DISCARD
  } state_t;

  function automatic int count_w(input int frame_bytes);
    return $clog2(frame_bytes + 1);
  endfunction

endpackage

// File: rtl/spi_cs_sync.sv
// Multi-stage synchroniser for the raw SPI chip-select; resets to the inactive (high) level.
module spi_cs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs_n_in,
  output logic cs_n_sync
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) pipe <= '1;
    else       pipe <= {pipe[STAGES-2:0], cs_n_in};
  end

  assign cs_n_sync = pipe[STAGES-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// Assembles SPI byte strobes into FRAME_BYTES-long frames bounded by chip-select,
// held on a valid/ready register; reports short, overrun and extra-byte errors.
module spi_frame_receiver
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BYTES = 3,
  parameter bit MULTI_FRAME = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BYTE_W-1:0]                 spi_data,
  input  logic                              spi_data_valid,
  input  logic                              spi_cs_n_in,
  output logic [BYTE_W*FRAME_BYTES-1:0]     frame_data,
  output logic                              frame_valid,
  input  logic                              frame_ready,
  output logic [count_w(FRAME_BYTES)-1:0]   byte_count,
  output logic                              frame_short,
  output logic                              frame_overrun,
  output logic                              frame_extra
);

  localparam int FW = BYTE_W * FRAME_BYTES;
  localparam int CW = count_w(FRAME_BYTES);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BYTES - 1);

  logic          cs_n_sync;
  logic          cs_act;
  state_t        state, state_nxt;
  logic [FW-1:0] assembled;
  logic          byte_in;
  logic          load;
  logic [CW-1:0] count_nxt;
  logic          valid_nxt;
  logic          short_nxt, overrun_nxt, extra_nxt;

  spi_cs_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .cs_n_in  (spi_cs_n_in),
    .cs_n_sync(cs_n_sync)
  );

  assign cs_act = ~cs_n_sync;

  // Older bytes simply shift out, so a dropped partial frame needs no clearing.
  if (FRAME_BYTES == 1) begin : g_single
    assign assembled = spi_data;
  end else begin : g_shift
    logic [FW-BYTE_W-1:0] shift;
    always_ff @(posedge clk) begin
      if (reset)        shift <= '0;
      else if (byte_in) shift <= assembled[FW-BYTE_W-1:0];
    end
    assign assembled = {shift, spi_data};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RESYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    byte_in     = 1'b0;
    load        = 1'b0;
    count_nxt   = byte_count;
    valid_nxt   = frame_valid && !frame_ready;
    short_nxt   = 1'b0;
    overrun_nxt = 1'b0;
    extra_nxt   = 1'b0;
    case (state)
      RESYNC: if (!cs_act) state_nxt = IDLE;
      IDLE: begin
        count_nxt = '0;
        if (cs_act) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (spi_data_valid) begin
          byte_in = 1'b1;
          if (byte_count == LAST) begin
            count_nxt   = '0;
            load        = !frame_valid || frame_ready;
            overrun_nxt = !load;
            if (load) valid_nxt = 1'b1;
            if (!MULTI_FRAME) state_nxt = DISCARD;
          end else begin
            count_nxt = byte_count + CW'(1);
          end
        end
        // The same-cycle byte is already folded into count_nxt here.
        if (!cs_act) begin
          state_nxt = IDLE;
          short_nxt = (count_nxt != '0);
          count_nxt = '0;
        end
      end
      DISCARD: begin
        extra_nxt = spi_data_valid;
        if (!cs_act) state_nxt = IDLE;
      end
      default: state_nxt = RESYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      byte_count    <= '0;
      frame_short   <= 1'b0;
      frame_overrun <= 1'b0;
      frame_extra   <= 1'b0;
    end else begin
      if (load) frame_data <= assembled;
      frame_valid   <= valid_nxt;
      byte_count    <= count_nxt;
      frame_short   <= short_nxt;
      frame_overrun <= overrun_nxt;
      frame_extra   <= extra_nxt;
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Bench for spi_frame_receiver: single-frame and multi-frame instances driven in parallel.
module tb_spi_frame_receiver;

  localparam int FB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  spi_data;
  logic        spi_data_valid;
  logic        spi_cs_n_in;
  logic        frame_ready;

  logic [23:0] d0_data, d1_data;
  logic        d0_valid, d1_valid;
  logic [1:0]  d0_count, d1_count;
  logic        d0_short, d0_over, d0_extra;
  logic        d1_short, d1_over, d1_extra;

  int tests = 0;
  int fails = 0;

  int s0 = 0, o0 = 0, e0 = 0, s1 = 0, o1 = 0, e1 = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];

  always #5 clk = ~clk;

  spi_frame_receiver #(.FRAME_BYTES(FB), .MULTI_FRAME(1'b0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
    .spi_cs_n_in(spi_cs_n_in), .frame_data(d0_data), .frame_valid(d0_valid),
    .frame_ready(frame_ready), .byte_count(d0_count), .frame_short(d0_short),
    .frame_overrun(d0_over), .frame_extra(d0_extra)
  );

  spi_frame_receiver #(.FRAME_BYTES(FB), .MULTI_FRAME(1'b1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .spi_data(spi_data), .spi_data_valid(spi_data_valid),
    .spi_cs_n_in(spi_cs_n_in), .frame_data(d1_data), .frame_valid(d1_valid),
    .frame_ready(frame_ready), .byte_count(d1_count), .frame_short(d1_short),
    .frame_overrun(d1_over), .frame_extra(d1_extra)
  );

  // Observer: records consumed frames and tallies error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (d0_valid && frame_ready) q0.push_back(d0_data);
      if (d1_valid && frame_ready) q1.push_back(d1_data);
      s0 += int'(d0_short); o0 += int'(d0_over); e0 += int'(d0_extra);
      s1 += int'(d1_short); o1 += int'(d1_over); e1 += int'(d1_extra);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data       = b;
    spi_data_valid = 1'b1;
    tick();
    spi_data_valid = 1'b0;
  endtask

  task automatic start_window();
    spi_cs_n_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic end_window();
    spi_cs_n_in = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int bs0, bs1, bo0, bo1, be0, be1, i0, i1;
    int exp_s0, exp_s1, exp_e0;
    logic [23:0] exp0[$];
    logic [23:0] exp1[$];
    logic [7:0]  bytes[8];
    int len;

    reset = 1'b1; spi_cs_n_in = 1'b1; spi_data = '0; spi_data_valid = 1'b0; frame_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", {d1_valid, d0_valid}, 0);
    check("rst_data", {d1_data, d0_data}, 0);
    check("rst_count", {d1_count, d0_count}, 0);
    check("rst_pulses", {d0_short, d0_over, d0_extra, d1_short, d1_over, d1_extra}, 0);
    reset = 1'b0;
    repeat (3) tick();

    // Basic frame, latency and handshake
    start_window();
    send_byte(8'hC1);
    check("count_after_1", {d1_count, d0_count}, {2'd1, 2'd1});
    send_byte(8'hC2);
    send_byte(8'hC3);
    check("frame_valid_n1", {d1_valid, d0_valid}, 2'b11);
    check("frame_data", d0_data, 24'hC1C2C3);
    check("frame_data_m", d1_data, 24'hC1C2C3);
    check("count_wrap", {d1_count, d0_count}, 0);
    frame_ready = 1'b1;
    tick();
    check("valid_cleared", {d1_valid, d0_valid}, 0);
    end_window();

    // Short frame then recovery
    bs0 = s0; bs1 = s1;
    start_window();
    send_byte(8'hC1);
    end_window();
    check("short_pulse", {s0 - bs0, s1 - bs1}, {32'd1, 32'd1});
    check("short_count", {d1_count, d0_count}, 0);
    check("short_valid", {d1_valid, d0_valid}, 0);
    frame_ready = 1'b0;
    start_window();
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    check("after_short", {d1_data, d0_data}, {24'hA1A2A3, 24'hA1A2A3});
    frame_ready = 1'b1;
    end_window();

    // Overrun: output full, consumer stalled
    frame_ready = 1'b0;
    bo0 = o0; bo1 = o1;
    start_window();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    end_window();
    start_window();
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
    end_window();
    check("overrun_pulse", {o0 - bo0, o1 - bo1}, {32'd1, 32'd1});
    check("overrun_held", {d1_data, d0_data}, {24'hC1C2C3, 24'hC1C2C3});
    check("overrun_valid", {d1_valid, d0_valid}, 2'b11);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    bo0 = o0; bo1 = o1;
    start_window();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    end_window();
    start_window();
    send_byte(8'hD1); send_byte(8'hD2);
    frame_ready = 1'b1;
    send_byte(8'hD3);
    check("ready_same_cycle", {d1_data, d0_data}, {24'hD1D2D3, 24'hD1D2D3});
    check("ready_same_valid", {d1_valid, d0_valid}, 2'b11);
    end_window();
    check("no_overrun", {o0 - bo0, o1 - bo1}, 0);

    // Extra bytes in one window
    i0 = q0.size(); i1 = q1.size(); bs0 = s0; bs1 = s1; be0 = e0; be1 = e1;
    start_window();
    for (int b = 8'h11; b <= 8'h15; b++) send_byte(8'(b));
    end_window();
    check("x5_frames0", q0.size() - i0, 1);
    check("x5_data0", q0[i0], 24'h111213);
    check("x5_extra0", e0 - be0, 2);
    check("x5_short0", s0 - bs0, 0);
    check("x5_frames1", q1.size() - i1, 1);
    check("x5_data1", q1[i1], 24'h111213);
    check("x5_short1", s1 - bs1, 1);
    i0 = q0.size(); i1 = q1.size(); be0 = e0; be1 = e1;
    start_window();
    for (int b = 8'h21; b <= 8'h26; b++) send_byte(8'(b));
    end_window();
    check("x6_frames0", q0.size() - i0, 1);
    check("x6_data0", q0[i0], 24'h212223);
    check("x6_extra0", e0 - be0, 3);
    check("x6_frames1", q1.size() - i1, 2);
    check("x6_data1a", q1[i1], 24'h212223);
    check("x6_data1b", q1[i1+1], 24'h242526);
    check("x6_extra1", e1 - be1, 0);

    // Reset in the middle of a window
    start_window();
    send_byte(8'h77); send_byte(8'h78);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    i0 = q0.size(); i1 = q1.size(); bs0 = s0; bs1 = s1;
    send_byte(8'h79);
    end_window();
    check("rst_mid_short", {s0 - bs0, s1 - bs1}, 0);
    check("rst_mid_valid", {d1_valid, d0_valid}, 0);
    check("rst_mid_frames", {q0.size() - i0, q1.size() - i1}, 0);
    start_window();
    send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
    check("rst_mid_next", {d1_data, d0_data}, {24'hE1E2E3, 24'hE1E2E3});
    end_window();

    // Last byte coincides with synchronised CS going inactive
    bs0 = s0; bs1 = s1;
    start_window();
    send_byte(8'hB1); send_byte(8'hB2);
    spi_cs_n_in = 1'b1;
    tick(); tick();
    send_byte(8'hB3);
    check("edge_valid", {d1_valid, d0_valid}, 2'b11);
    check("edge_data", {d1_data, d0_data}, {24'hB1B2B3, 24'hB1B2B3});
    repeat (4) tick();
    check("edge_short", {s0 - bs0, s1 - bs1}, 0);

    // Random windows against a frame-level model
    i0 = q0.size(); i1 = q1.size(); bs0 = s0; bs1 = s1; be0 = e0;
    exp_s0 = 0; exp_s1 = 0; exp_e0 = 0;
    for (int w = 0; w < 25; w++) begin
      len = $urandom_range(0, 7);
      for (int k = 0; k < len; k++) bytes[k] = 8'($urandom);
      if (len >= FB) begin
        exp0.push_back({bytes[0], bytes[1], bytes[2]});
        exp_e0 += len - FB;
      end else if (len > 0) begin
        exp_s0++;
      end
      for (int f = 0; f < len / FB; f++)
        exp1.push_back({bytes[f*FB], bytes[f*FB+1], bytes[f*FB+2]});
      if (len % FB != 0) exp_s1++;
      start_window();
      for (int k = 0; k < len; k++) begin
        send_byte(bytes[k]);
        repeat ($urandom_range(0, 2)) tick();
      end
      end_window();
    end
    check("rnd_count0", q0.size() - i0, exp0.size());
    check("rnd_count1", q1.size() - i1, exp1.size());
    for (int k = 0; k < exp0.size() && i0 + k < q0.size(); k++)
      check("rnd_frame0", q0[i0+k], exp0[k]);
    for (int k = 0; k < exp1.size() && i1 + k < q1.size(); k++)
      check("rnd_frame1", q1[i1+k], exp1[k]);
    check("rnd_short0", s0 - bs0, exp_s0);
    check("rnd_short1", s1 - bs1, exp_s1);
    check("rnd_extra0", e0 - be0, exp_e0);
    check("total_overrun_m", o1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
